// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads combinational instruction memory and
// hands fetched instructions to decode over valid/ready, with redirect/flush from execute.
module instruction_fetch_unit #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         DATA_W   = 32,
    parameter logic [ADDR_W+1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_enable,
    output logic [ADDR_W-1:0]   instruction_address,
    input  logic [DATA_W-1:0]   instruction_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W+1:0]   redirect_pc,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [DATA_W-1:0]   fetch_instruction,
    output logic [ADDR_W+1:0]   fetch_pc,
    output logic                misalign_error
);

    localparam logic [ADDR_W+1:0] PC_STEP = (ADDR_W+2)'(4);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic                w_fetch;

    logic [ADDR_W+1:0]   r_pc;
    logic                r_fetch_valid;
    logic [DATA_W-1:0]   r_fetch_instruction;
    logic [ADDR_W+1:0]   r_fetch_pc;
    logic                r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RUN only drops to IDLE once the output register is empty or being accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (fetch_enable) w_state_next = RUN;
            RUN:     if (!fetch_enable && w_load) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_load  = !r_fetch_valid || fetch_ready;
        w_fetch = (r_state == RUN) && fetch_enable && w_load && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc                <= RESET_PC;
            r_fetch_valid       <= 1'b0;
            r_fetch_instruction <= '0;
            r_fetch_pc          <= '0;
            r_misalign          <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect flushes the pending word even while decode is stalling.
            r_pc          <= {redirect_pc[ADDR_W+1:2], 2'b00};
            r_fetch_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else if (w_fetch) begin
            r_fetch_instruction <= instruction_data;
            r_fetch_pc          <= r_pc;
            r_fetch_valid       <= 1'b1;
            r_pc                <= r_pc + PC_STEP;
        end else if (w_load) begin
            r_fetch_valid <= 1'b0;
        end
    end

    assign instruction_address = r_pc[ADDR_W+1:2];
    assign fetch_valid         = r_fetch_valid;
    assign fetch_instruction   = r_fetch_instruction;
    assign fetch_pc            = r_fetch_pc;
    assign misalign_error      = r_misalign;

endmodule
